// File: rtl/eeg_pkg.sv
// Shared types and constants for the EEG window/std-dev feature path.
package eeg_pkg;

  localparam int FRAC_BITS = 12;
  localparam int INT_BITS  = 5;
  localparam int STD_WIDTH = 19;

  typedef logic signed [17:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    MEAN_DIV,
    REPLAY,
    FLUSH,
    WAIT_SQRT
  } seq_state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses once
// NW cycles after the start cycle.
module seq_divider #(
  parameter int NW = 26,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(NW + 1);

  logic [DW-1:0] rem;
  logic [NW-1:0] quo;
  logic [CW-1:0] cnt;
  logic          run;
  logic [DW:0]   shifted;
  logic [DW-1:0] diff;
  logic          fits;

  // Partial remainder stays below divisor, so the difference fits DW bits.
  assign shifted  = {rem, quo[NW-1]};
  assign fits     = shifted >= {1'b0, divisor};
  assign diff     = shifted[DW-1:0] - divisor;
  assign quotient = quo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= '0;
        quo <= dividend;
        cnt <= CW'(NW);
        run <= 1'b1;
      end else if (run) begin
        rem <= fits ? diff : shifted[DW-1:0];
        quo <= {quo[NW-2:0], fits};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eeg_window_sequencer.sv
// Buffers one EEG window, computes its mean, replays it into std_calc and
// republishes the resulting standard deviation.
module eeg_window_sequencer
  import eeg_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 8,
  parameter int START_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [ADDR_WIDTH-1:0] window_len,
  output logic                  busy,
  output logic                  overrun,
  output logic                  start,
  output logic [DATA_WIDTH-1:0] eeg,
  output logic [DATA_WIDTH-1:0] mean,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  complete_acc,
  input  logic                  complete_sqrt,
  input  logic [STD_WIDTH-1:0]  std_dev_in,
  output logic [STD_WIDTH-1:0]  std_out,
  output logic                  std_valid
);

  localparam int SW    = DATA_WIDTH + ADDR_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int GW    = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
  localparam logic [GW-1:0]         GAP_RELOAD = GW'(START_GAP - 1);

  seq_state_e state, state_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, eff_len;
  logic signed [SW-1:0]  sum, sample_ext;
  logic [SW-1:0]         sum_abs, div_quo;
  logic [GW-1:0]         gap;
  logic                  div_start, div_done;
  logic accept_first, accept, fill_done, mean_load, issue, fire_acc, fire_std, drop;

  // Short windows clamp to 2 so std_calc never divides by count-1 = 0.
  assign eff_len    = (window_len < ADDR_WIDTH'(2)) ? ADDR_WIDTH'(2) : window_len;
  assign sample_ext = {{ADDR_WIDTH{sample[DATA_WIDTH-1]}}, sample};
  assign sum_abs    = sum[SW-1] ? $unsigned(-sum) : $unsigned(sum);
  assign busy       = (state != IDLE);

  seq_divider #(.NW(SW), .DW(ADDR_WIDTH)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (sum_abs),
    .divisor  (count),
    .quotient (div_quo),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n      = state;
    accept_first = 1'b0;
    accept       = 1'b0;
    fill_done    = 1'b0;
    mean_load    = 1'b0;
    issue        = 1'b0;
    fire_acc     = 1'b0;
    fire_std     = 1'b0;
    drop         = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          accept_first = 1'b1;
          state_n      = FILL;
        end
      end
      FILL: begin
        if (sample_valid) begin
          accept = 1'b1;
          if (wr_ptr == count - ONE) begin
            fill_done = 1'b1;
            state_n   = MEAN_DIV;
          end
        end
      end
      MEAN_DIV: begin
        drop = sample_valid;
        if (div_done) begin
          mean_load = 1'b1;
          state_n   = REPLAY;
        end
      end
      REPLAY: begin
        drop = sample_valid;
        if (gap == '0) begin
          issue = 1'b1;
          if (rd_ptr == count - ONE) state_n = FLUSH;
        end
      end
      FLUSH: begin
        drop = sample_valid;
        if (gap == '0) begin
          fire_acc = 1'b1;
          state_n  = WAIT_SQRT;
        end
      end
      WAIT_SQRT: begin
        drop = sample_valid;
        if (complete_sqrt) begin
          fire_std = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept_first)  mem[0]      <= sample;
    else if (accept)   mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start        <= 1'b0;
      complete_acc <= 1'b0;
      std_valid    <= 1'b0;
      div_start    <= 1'b0;
      overrun      <= 1'b0;
      count        <= '0;
      sum          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      gap          <= '0;
      eeg          <= '0;
      mean         <= '0;
      std_out      <= '0;
    end else begin
      start        <= issue;
      complete_acc <= fire_acc;
      std_valid    <= fire_std;
      div_start    <= fill_done;
      if (accept_first) begin
        count   <= eff_len;
        sum     <= sample_ext;
        wr_ptr  <= ONE;
        overrun <= 1'b0;
      end else if (accept) begin
        sum    <= sum + sample_ext;
        wr_ptr <= wr_ptr + ONE;
      end
      if (drop) overrun <= 1'b1;
      // Sign is reapplied to the magnitude quotient: truncation toward zero.
      if (mean_load) begin
        mean   <= sum[SW-1] ? DATA_WIDTH'(-div_quo) : DATA_WIDTH'(div_quo);
        rd_ptr <= '0;
        gap    <= '0;
      end
      if (issue) begin
        eeg    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ONE;
        gap    <= GAP_RELOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      if (fire_std) std_out <= std_dev_in;
    end
  end

endmodule

// File: tb/tb_eeg_window_sequencer.sv
// Directed bench: windows are fed, replayed samples are scoreboarded against
// a queue, and mean/count/timing/handshake/overrun/reset behaviour is checked.
module tb_eeg_window_sequencer;
  import eeg_pkg::*;

  localparam int DW  = 18;
  localparam int AW  = 8;
  localparam int GAP = 4;
  localparam int FIRST_START_LAT = DW + AW + 3;

  logic           clk, reset_n;
  logic           sample_valid;
  logic [DW-1:0]  sample;
  logic [AW-1:0]  window_len;
  logic           busy, overrun, start, complete_acc, complete_sqrt, std_valid;
  logic [DW-1:0]  eeg, mean;
  logic [AW-1:0]  count;
  logic [STD_WIDTH-1:0] std_dev_in, std_out;

  eeg_window_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_GAP(GAP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .window_len   (window_len),
    .busy         (busy),
    .overrun      (overrun),
    .start        (start),
    .eeg          (eeg),
    .mean         (mean),
    .count        (count),
    .complete_acc (complete_acc),
    .complete_sqrt(complete_sqrt),
    .std_dev_in   (std_dev_in),
    .std_out      (std_out),
    .std_valid    (std_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_sample_cyc = 0;
  int last_start_cyc = 0;
  int win_starts = 0;
  int total_starts = 0;
  int acc_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_mean = '0;
  logic [DW-1:0] smp[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Replay monitor: pops the scoreboard on each start and checks spacing.
  always @(negedge clk) begin
    if (reset_n) begin
      if (start) begin
        if (exp_q.size() == 0) chk("unexpected_start", 32'(eeg), 32'hFFFF_FFFF);
        else chk("eeg_replay", 32'(eeg), 32'(exp_q.pop_front()));
        chk("mean_at_start", 32'(mean), 32'(exp_mean));
        if (win_starts == 0) chk("first_start_lat", cyc - last_sample_cyc, FIRST_START_LAT);
        else                 chk("start_gap", cyc - last_start_cyc, GAP);
        last_start_cyc = cyc;
        win_starts++;
        total_starts++;
      end
      if (complete_acc) begin
        chk("acc_gap", cyc - last_start_cyc, GAP);
        acc_cnt++;
      end
    end
  end

  task automatic set4(input logic [DW-1:0] a, b, c, d);
    smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
  endtask

  task automatic feed(input int len, input int n, input logic [DW-1:0] m_exp, input bit gaps);
    win_starts = 0;
    exp_mean   = m_exp;
    for (int i = 0; i < n; i++) begin
      window_len   = AW'(len);
      sample       = smp[i];
      sample_valid = 1'b1;
      exp_q.push_back(smp[i]);
      @(posedge clk); #1;
      last_sample_cyc = cyc;
      if (i == 0) chk("overrun_clear", 32'(overrun), 0);
      if (gaps) begin
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_window(input int len, input int n, input logic [DW-1:0] m_exp,
                            input logic [AW-1:0] c_exp, input logic [STD_WIDTH-1:0] sd,
                            input bit gaps, input bit hold);
    int acc0;
    acc0 = acc_cnt;
    feed(len, n, m_exp, gaps);
    sample_valid = hold;
    sample       = 18'h1ABCD;
    for (int k = 0; k < 400 && acc_cnt == acc0; k++) begin
      @(posedge clk); #1;
    end
    chk("acc_seen", acc_cnt - acc0, 1);
    chk("start_count", win_starts, n);
    chk("mean", 32'(mean), 32'(m_exp));
    chk("count", 32'(count), 32'(c_exp));
    chk("queue_drained", exp_q.size(), 0);
    if (hold) chk("overrun_set", 32'(overrun), 1);
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_wait_sqrt", 32'(busy), 1);
    complete_sqrt = 1'b1;
    std_dev_in    = sd;
    @(posedge clk); #1;
    complete_sqrt = 1'b0;
    chk("std_valid_pulse", 32'(std_valid), 1);
    chk("std_out", 32'(std_out), 32'(sd));
    chk("busy_after", 32'(busy), 0);
    @(posedge clk); #1;
    chk("std_valid_drop", 32'(std_valid), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_ovr"},    32'(overrun), 0);
    chk({tag, "_start"},  32'(start), 0);
    chk({tag, "_eeg"},    32'(eeg), 0);
    chk({tag, "_mean"},   32'(mean), 0);
    chk({tag, "_count"},  32'(count), 0);
    chk({tag, "_acc"},    32'(complete_acc), 0);
    chk({tag, "_std"},    32'(std_out), 0);
    chk({tag, "_stdv"},   32'(std_valid), 0);
  endtask

  initial begin
    int starts0, acc0;
    reset_n = 1'b0; sample_valid = 1'b0; sample = '0; window_len = '0;
    complete_sqrt = 1'b0; std_dev_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    set4(18'h00800, 18'h02000, 18'h00400, 18'h08800);
    run_window(4, 4, 18'h02D00, 8'd4, 19'h01234, 1'b1, 1'b0);

    set4(18'h3F000, 18'h3E000, 18'h0, 18'h0);
    run_window(2, 2, 18'h3E800, 8'd2, 19'h00100, 1'b0, 1'b0);

    set4(18'h3FFFF, 18'h0, 18'h0, 18'h0);
    run_window(3, 3, 18'h00000, 8'd3, 19'h00200, 1'b0, 1'b0);

    set4(18'h00001, 18'h0, 18'h0, 18'h0);
    run_window(3, 3, 18'h00000, 8'd3, 19'h00300, 1'b0, 1'b0);

    set4(18'h01000, 18'h03000, 18'h0, 18'h0);
    run_window(1, 2, 18'h02000, 8'd2, 19'h03F00, 1'b0, 1'b0);

    set4(18'h00100, 18'h3FF00, 18'h00200, 18'h00300);
    run_window(4, 4, 18'h00140, 8'd4, 19'h00400, 1'b0, 1'b1);
    chk("overrun_sticky", 32'(overrun), 1);

    set4(18'h00400, 18'h00600, 18'h0, 18'h0);
    run_window(2, 2, 18'h00500, 8'd2, 19'h00500, 1'b0, 1'b0);

    // Abort during replay after the second start.
    set4(18'h00010, 18'h00020, 18'h00030, 18'h00040);
    feed(4, 4, 18'h00028, 1'b0);
    sample_valid = 1'b0;
    for (int k = 0; k < 200 && win_starts < 2; k++) begin
      @(posedge clk); #1;
    end
    chk("abort_two_starts", win_starts, 2);
    reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    starts0 = total_starts;
    acc0    = acc_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_start", total_starts, starts0);
    chk("abort_no_acc", acc_cnt, acc0);
    chk("abort_idle", 32'(busy), 0);

    set4(18'h00300, 18'h00600, 18'h00900, 18'h0);
    run_window(3, 3, 18'h00600, 8'd3, 19'h00777, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
